framebuffer_op_scheduler: RTL and testbench
===========================================

FRAMEBUFFER_OP_SCHEDULER -- requirements
Module: framebuffer_op_scheduler

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2, which sets the consecutive idle-pipeline cycles required before an apply.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, which sets the applied-wait limit (used only with FB_OP_TIMEOUT_EN).
REQ-003 SHALL have port aclk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports s_op_tvalid in 1 / s_op_tready out 1, the operation request handshake.
REQ-006 SHALL have ports s_op_commit, s_op_memset, s_op_color and s_op_depth, each in 1: the op kind and target selects.
REQ-007 SHALL have ports s_op_clear_color and s_op_clear_depth, each in 16, carrying the memset values.
REQ-008 SHALL have ports pixelInPipeline in 1 and rasterizerRunning in 1, the pipeline activity inputs.
REQ-009 SHALL have ports colorBufferApply out 1, colorBufferApplied in 1, colorBufferCmdCommit out 1, colorBufferCmdMemset out 1 and confColorBufferClearColor out 16.
REQ-010 SHALL have ports depthBufferApply out 1, depthBufferApplied in 1, depthBufferCmdCommit out 1, depthBufferCmdMemset out 1 and confDepthBufferClearDepth out 16.
REQ-011 SHALL have ports busy out 1, opDone out 1 (one-cycle pulse) and opError out 1 (timeout flag).

Function
REQ-012 SHALL implement states IDLE, DRAIN, APPLY, WAIT and DONE; all outputs SHALL be registered.
REQ-013 In IDLE, s_op_tready SHALL be 1; in every other state it SHALL be 0.
REQ-014 On handshake (tvalid and tready), SHALL capture all op fields, clear opError, and enter DRAIN.
REQ-015 The Cmd* and conf* outputs SHALL be driven from the captured fields and held stable from DRAIN until IDLE is re-entered.
REQ-016 If (commit|memset)==0 or (color|depth)==0, the op SHALL go directly to DONE with no apply issued.
REQ-017 In DRAIN, a counter SHALL increment each cycle pixelInPipeline==0 and rasterizerRunning==0, and SHALL clear to 0 otherwise.
REQ-018 The block SHALL enter APPLY once the counter reaches DRAIN_CYCLES; with DRAIN_CYCLES=0, DRAIN SHALL last exactly one cycle.
REQ-019 APPLY SHALL last exactly one cycle, asserting xBufferApply=1 only for selected targets, and SHALL load a pending mask {color,depth} from the selects.
REQ-020 Applied inputs SHALL be sampled from the APPLY cycle onward; an asserted applied SHALL clear its pending bit.
REQ-021 Applied on an unselected target SHALL be ignored.
REQ-022 WAIT SHALL exit to DONE when the pending mask is 0, including the case where both applied arrive in the same cycle.
REQ-023 DONE SHALL last one cycle with opDone=1, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Nominal latency with an idle pipeline, DRAIN_CYCLES=2 and applied returned in the first WAIT cycle, handshake at cycle T: DRAIN T+1..T+2, APPLY T+3, WAIT T+4, opDone T+5, tready=1 at T+6.
REQ-026 A pipeline becoming active during DRAIN SHALL restart the count; the apply SHALL never be issued while pixelInPipeline or rasterizerRunning is high.

Reset
REQ-027 On resetn low, the state SHALL go to IDLE asynchronously, counters and pending SHALL clear, and all outputs SHALL be 0, including s_op_tready.
REQ-028 s_op_tready SHALL rise on the first aclk edge after resetn deasserts.
REQ-029 Reset mid-operation SHALL abandon the op silently, with no opDone pulse.

Configuration
REQ-030 With macro FB_OP_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; reaching TIMEOUT_CYCLES with pending!=0 SHALL go to DONE with opError=1 alongside opDone.
REQ-031 With FB_OP_TIMEOUT_EN defined, opError SHALL stay 1 until the next accepted op.
REQ-032 Without FB_OP_TIMEOUT_EN, WAIT SHALL persist indefinitely, opError SHALL be constant 0, and no timeout counter SHALL be synthesized.

Verification
REQ-033 Scenario: commit+memset on color and depth, clears 0x1234/0xFFFF, pipeline idle, both applied at T+4 -> both apply pulses at T+3, conf outputs 0x1234/0xFFFF, opDone at T+5.
REQ-034 Scenario: pixelInPipeline high for T+1..T+10, then low -> APPLY at T+13, no earlier apply.
REQ-035 Scenario: color-only commit; depthBufferApplied pulses in WAIT; colorBufferApplied arrives at T+8 -> depthBufferApply never asserted, stray depth applied ignored, opDone at T+9.
REQ-036 Scenario: op with color=depth=0 -> no apply pulses, opDone at T+1, tready=1 at T+2.
REQ-037 Scenario: resetn asserted during WAIT -> all outputs 0 immediately, no opDone, tready=1 after release.
REQ-038 Scenario: FB_OP_TIMEOUT_EN with TIMEOUT_CYCLES=16 and applied never asserted -> opDone and opError at T+20, opError held until the next handshake.

Source files
------------

// File: rtl/framebuffer_op_scheduler.sv
// Sequences framebuffer commit/memset ops: drain the pipeline, pulse apply, wait for applied. Optional macro FB_OP_TIMEOUT_EN.
// Latency: handshake T -> DRAIN T+1..T+DRAIN_CYCLES, APPLY, WAIT (>=1 cycle), opDone one cycle later.
// Backpressure: s_op_tready is high only in IDLE; one op in flight at a time.
module framebuffer_op_scheduler #(
   parameter int unsigned DRAIN_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        aclk,
   input  logic        resetn,
   input  logic        s_op_tvalid,
   output logic        s_op_tready,
   input  logic        s_op_commit,
   input  logic        s_op_memset,
   input  logic        s_op_color,
   input  logic        s_op_depth,
   input  logic [15:0] s_op_clear_color,
   input  logic [15:0] s_op_clear_depth,
   input  logic        pixelInPipeline,
   input  logic        rasterizerRunning,
   output logic        colorBufferApply,
   input  logic        colorBufferApplied,
   output logic        colorBufferCmdCommit,
   output logic        colorBufferCmdMemset,
   output logic [15:0] confColorBufferClearColor,
   output logic        depthBufferApply,
   input  logic        depthBufferApplied,
   output logic        depthBufferCmdCommit,
   output logic        depthBufferCmdMemset,
   output logic [15:0] confDepthBufferClearDepth,
   output logic        busy,
   output logic        opDone,
   output logic        opError
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_APPLY,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t      state;
   logic        sel_color;
   logic        sel_depth;
   logic [1:0]  pending;
   logic [31:0] drain_cnt;
   logic        pipe_idle;
   logic        drain_done;
   logic [1:0]  pend_nxt;
   logic        op_nop;

   assign pipe_idle  = !pixelInPipeline && !rasterizerRunning;
   // A zero drain length means DRAIN is a single pass-through cycle.
   assign drain_done = (DRAIN_CYCLES == 0) ||
                       (pipe_idle && ((drain_cnt + 32'd1) >= DRAIN_CYCLES));
   assign pend_nxt   = pending & ~{colorBufferApplied, depthBufferApplied};
   assign op_nop     = !(s_op_commit || s_op_memset) || !(s_op_color || s_op_depth);

`ifdef FB_OP_TIMEOUT_EN
   logic [31:0] wait_cnt;
`else
   // No timeout in this build: opError is tied low.
   localparam bit NO_TIMEOUT_ERR = (TIMEOUT_CYCLES != 0) && 1'b0;
   assign opError = NO_TIMEOUT_ERR;
`endif

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state                     <= ST_IDLE;
         sel_color                 <= 1'b0;
         sel_depth                 <= 1'b0;
         pending                   <= 2'b00;
         drain_cnt                 <= 32'd0;
         s_op_tready               <= 1'b0;
         colorBufferApply          <= 1'b0;
         colorBufferCmdCommit      <= 1'b0;
         colorBufferCmdMemset      <= 1'b0;
         confColorBufferClearColor <= 16'h0000;
         depthBufferApply          <= 1'b0;
         depthBufferCmdCommit      <= 1'b0;
         depthBufferCmdMemset      <= 1'b0;
         confDepthBufferClearDepth <= 16'h0000;
         busy                      <= 1'b0;
         opDone                    <= 1'b0;
`ifdef FB_OP_TIMEOUT_EN
         wait_cnt                  <= 32'd0;
         opError                   <= 1'b0;
`endif
      end else begin
         colorBufferApply <= 1'b0;
         depthBufferApply <= 1'b0;
         opDone           <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s_op_tvalid && s_op_tready) begin
                  sel_color                 <= s_op_color;
                  sel_depth                 <= s_op_depth;
                  colorBufferCmdCommit      <= s_op_commit & s_op_color;
                  colorBufferCmdMemset      <= s_op_memset & s_op_color;
                  depthBufferCmdCommit      <= s_op_commit & s_op_depth;
                  depthBufferCmdMemset      <= s_op_memset & s_op_depth;
                  confColorBufferClearColor <= s_op_clear_color;
                  confDepthBufferClearDepth <= s_op_clear_depth;
                  drain_cnt                 <= 32'd0;
                  s_op_tready               <= 1'b0;
                  busy                      <= 1'b1;
`ifdef FB_OP_TIMEOUT_EN
                  opError                   <= 1'b0;
`endif
                  if (op_nop) begin
                     state  <= ST_DONE;
                     opDone <= 1'b1;
                  end else begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  s_op_tready <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state            <= ST_APPLY;
                  colorBufferApply <= sel_color;
                  depthBufferApply <= sel_depth;
                  pending          <= {sel_color, sel_depth};
               end else if (pipe_idle) begin
                  drain_cnt <= drain_cnt + 32'd1;
               end else begin
                  drain_cnt <= 32'd0;
               end
            end
            ST_APPLY: begin
               // Applied may already return while the apply pulse is out.
               pending <= pend_nxt;
               state   <= ST_WAIT;
`ifdef FB_OP_TIMEOUT_EN
               wait_cnt <= 32'd0;
`endif
            end
            ST_WAIT: begin
               pending <= pend_nxt;
               if (pend_nxt == 2'b00) begin
                  state  <= ST_DONE;
                  opDone <= 1'b1;
`ifdef FB_OP_TIMEOUT_EN
               end else if ((wait_cnt + 32'd1) >= TIMEOUT_CYCLES) begin
                  state   <= ST_DONE;
                  opDone  <= 1'b1;
                  opError <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
`endif
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               pending     <= 2'b00;
               s_op_tready <= 1'b1;
               busy        <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               s_op_tready <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_framebuffer_op_scheduler.sv
// Directed bench for framebuffer_op_scheduler; cycle T is the handshake cycle.
module tb_framebuffer_op_scheduler;

   logic        aclk = 1'b0;
   logic        resetn = 1'b0;
   logic        s_op_tvalid = 1'b0;
   logic        s_op_tready;
   logic        s_op_commit = 1'b0;
   logic        s_op_memset = 1'b0;
   logic        s_op_color = 1'b0;
   logic        s_op_depth = 1'b0;
   logic [15:0] s_op_clear_color = 16'h0;
   logic [15:0] s_op_clear_depth = 16'h0;
   logic        pixelInPipeline = 1'b0;
   logic        rasterizerRunning = 1'b0;
   logic        colorBufferApply;
   logic        colorBufferApplied = 1'b0;
   logic        colorBufferCmdCommit;
   logic        colorBufferCmdMemset;
   logic [15:0] confColorBufferClearColor;
   logic        depthBufferApply;
   logic        depthBufferApplied = 1'b0;
   logic        depthBufferCmdCommit;
   logic        depthBufferCmdMemset;
   logic [15:0] confDepthBufferClearDepth;
   logic        busy;
   logic        opDone;
   logic        opError;

   int total_cnt = 0;
   int pass_cnt  = 0;
   int bad;

   framebuffer_op_scheduler #(.DRAIN_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
      .aclk(aclk), .resetn(resetn),
      .s_op_tvalid(s_op_tvalid), .s_op_tready(s_op_tready),
      .s_op_commit(s_op_commit), .s_op_memset(s_op_memset),
      .s_op_color(s_op_color), .s_op_depth(s_op_depth),
      .s_op_clear_color(s_op_clear_color), .s_op_clear_depth(s_op_clear_depth),
      .pixelInPipeline(pixelInPipeline), .rasterizerRunning(rasterizerRunning),
      .colorBufferApply(colorBufferApply), .colorBufferApplied(colorBufferApplied),
      .colorBufferCmdCommit(colorBufferCmdCommit), .colorBufferCmdMemset(colorBufferCmdMemset),
      .confColorBufferClearColor(confColorBufferClearColor),
      .depthBufferApply(depthBufferApply), .depthBufferApplied(depthBufferApplied),
      .depthBufferCmdCommit(depthBufferCmdCommit), .depthBufferCmdMemset(depthBufferCmdMemset),
      .confDepthBufferClearDepth(confDepthBufferClearDepth),
      .busy(busy), .opDone(opDone), .opError(opError)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // Waits (bounded) for tready, drives one op, returns in cycle T+1.
   task automatic start_op(input logic cm, input logic ms, input logic co, input logic de,
                           input logic [15:0] cc, input logic [15:0] cd);
      int guard;
      guard = 0;
      while (s_op_tready !== 1'b1 && guard < 50) begin
         tick(1);
         guard++;
      end
      if (guard >= 50) chk("tready_timeout", {31'b0, s_op_tready}, 32'd1);
      s_op_tvalid = 1'b1;
      s_op_commit = cm;
      s_op_memset = ms;
      s_op_color  = co;
      s_op_depth  = de;
      s_op_clear_color = cc;
      s_op_clear_depth = cd;
      tick(1);
      s_op_tvalid = 1'b0;
   endtask

   function automatic logic [31:0] all_outs();
      return {15'b0, s_op_tready, colorBufferApply, colorBufferCmdCommit, colorBufferCmdMemset,
              depthBufferApply, depthBufferCmdCommit, depthBufferCmdMemset, busy, opDone, opError,
              |confColorBufferClearColor, |confDepthBufferClearDepth, 4'b0};
   endfunction

   initial begin
      // Reset state and tready release on the first edge.
      #12;
      chk("reset_outputs", all_outs(), 32'd0);
      @(posedge aclk);
      #1;
      chk("reset_held_tready", {31'b0, s_op_tready}, 32'd0);
      resetn = 1'b1;
      #2;
      chk("tready_before_edge", {31'b0, s_op_tready}, 32'd0);
      tick(1);
      chk("tready_after_release", {31'b0, s_op_tready}, 32'd1);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      // Commit+memset on both targets, idle pipeline, applied at T+4.
      start_op(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'hFFFF);
      chk("op1_t1_busy_tready", {30'b0, busy, s_op_tready}, 32'b10);
      chk("op1_conf_color", {16'b0, confColorBufferClearColor}, 32'h1234);
      chk("op1_conf_depth", {16'b0, confDepthBufferClearDepth}, 32'hFFFF);
      chk("op1_cmds", {28'b0, colorBufferCmdCommit, colorBufferCmdMemset,
                       depthBufferCmdCommit, depthBufferCmdMemset}, 32'hF);
      chk("op1_t1_apply", {30'b0, colorBufferApply, depthBufferApply}, 32'd0);
      tick(1);
      chk("op1_t2_apply", {30'b0, colorBufferApply, depthBufferApply}, 32'd0);
      tick(1);
      chk("op1_t3_apply", {30'b0, colorBufferApply, depthBufferApply}, 32'b11);
      tick(1);
      chk("op1_t4_apply_off", {30'b0, colorBufferApply, depthBufferApply}, 32'd0);
      colorBufferApplied = 1'b1;
      depthBufferApplied = 1'b1;
      tick(1);
      colorBufferApplied = 1'b0;
      depthBufferApplied = 1'b0;
      chk("op1_t5_opdone", {31'b0, opDone}, 32'd1);
      chk("op1_t5_conf_hold", {16'b0, confColorBufferClearColor}, 32'h1234);
      tick(1);
      chk("op1_t6_ready", {29'b0, s_op_tready, busy, opDone}, 32'b100);

      // pixelInPipeline high T+1..T+10: APPLY must land at T+13.
      start_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
      pixelInPipeline = 1'b1;
      bad = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 11) pixelInPipeline = 1'b0;
         if (colorBufferApply || depthBufferApply) bad++;
         if (c < 12) tick(1);
      end
      chk("op2_no_early_apply", bad, 32'd0);
      tick(1);
      chk("op2_t13_apply", {30'b0, colorBufferApply, depthBufferApply}, 32'b11);
      colorBufferApplied = 1'b1;
      depthBufferApplied = 1'b1;
      tick(1);
      colorBufferApplied = 1'b0;
      depthBufferApplied = 1'b0;
      chk("op2_t14_no_done", {31'b0, opDone}, 32'd0);
      tick(1);
      chk("op2_t15_opdone", {31'b0, opDone}, 32'd1);

      // Color-only commit with a stray depth applied; color applied at T+8.
      start_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 16'h0055);
      chk("op3_cmds", {30'b0, colorBufferCmdCommit, colorBufferCmdMemset}, 32'b10);
      bad = 0;
      for (int c = 1; c <= 8; c++) begin
         if (depthBufferApply) bad++;
         if (c == 3) chk("op3_t3_color_apply", {31'b0, colorBufferApply}, 32'd1);
         depthBufferApplied = (c == 5);
         colorBufferApplied = (c == 8);
         if (c == 8) chk("op3_t8_no_done", {31'b0, opDone}, 32'd0);
         tick(1);
      end
      depthBufferApplied = 1'b0;
      colorBufferApplied = 1'b0;
      chk("op3_depth_never_applied", bad, 32'd0);
      chk("op3_t9_opdone", {31'b0, opDone}, 32'd1);

      // No target selected: DONE at T+1, ready at T+2.
      tick(1);
      start_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("op4_t1_opdone_noapply", {29'b0, opDone, colorBufferApply, depthBufferApply}, 32'b100);
      tick(1);
      chk("op4_t2_tready", {30'b0, s_op_tready, opDone}, 32'b10);
      // No op kind selected behaves the same.
      start_op(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
      chk("op4b_t1_opdone", {31'b0, opDone}, 32'd1);
      tick(1);

      // rasterizerRunning at T+2 restarts the drain count: APPLY at T+5.
      start_op(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0BEE);
      tick(1);
      rasterizerRunning = 1'b1;
      tick(1);
      rasterizerRunning = 1'b0;
      chk("op5_t3_no_apply", {31'b0, depthBufferApply}, 32'd0);
      tick(1);
      chk("op5_t4_no_apply", {31'b0, depthBufferApply}, 32'd0);
      tick(1);
      chk("op5_t5_apply", {30'b0, colorBufferApply, depthBufferApply}, 32'b01);
      depthBufferApplied = 1'b1;
      tick(1);
      depthBufferApplied = 1'b0;
      tick(1);
      chk("op5_t7_opdone", {31'b0, opDone}, 32'd1);
      tick(1);

      // Reset during WAIT abandons the op silently.
      start_op(1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 16'hBEEF);
      tick(4);
      chk("op6_in_wait_busy", {31'b0, busy}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("op6_reset_outputs", all_outs(), 32'd0);
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         if (opDone) bad++;
      end
      resetn = 1'b1;
      tick(1);
      if (opDone) bad++;
      chk("op6_no_opdone", bad, 32'd0);
      chk("op6_tready_after_release", {30'b0, s_op_tready, busy}, 32'b10);

`ifdef FB_OP_TIMEOUT_EN
      // Applied never returns: timeout DONE at T+20 with opError.
      start_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
      tick(18);
      chk("op7_t19_no_done", {30'b0, opDone, opError}, 32'd0);
      tick(1);
      chk("op7_t20_done_err", {30'b0, opDone, opError}, 32'b11);
      tick(3);
      chk("op7_err_held", {30'b0, opError, s_op_tready}, 32'b11);
      start_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("op7_err_cleared", {31'b0, opError}, 32'd0);
      tick(1);
`else
      chk("no_timeout_err_zero", {31'b0, opError}, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
